cp0_exception_unit: RTL and testbench
=====================================

CP0_EXCEPTION_UNIT -- requirements
Module: cp0_exception_unit

Interface
REQ-001 SHALL have parameter HANDLER_VECTOR, default 32'h0000_0180, the exception handler entry address.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port exception  input  1  a synchronous exception is flagged this cycle.
REQ-005 SHALL have port cause_in  input  32  exception code; bit0 illegal inst, bit1 illegal ALU ctrl, bit2 overflow.
REQ-006 SHALL have port epc_in  input  32  address of the faulting instruction.
REQ-007 SHALL have port eret  input  1  exception-return instruction in execute.
REQ-008 SHALL have ports mtc0_en  input  1, wr_addr  input  5, wr_data  input  32  CP0 write request.
REQ-009 SHALL have ports rd_addr  input  5 and rd_data  output  32  combinational CP0 read (mfc0).
REQ-010 SHALL have ports flush  output  1, pc_redirect  output  1, redirect_pc  output  32  pipeline control.
REQ-011 SHALL have port exl  output  1  mirror of Status.EXL.

Function
REQ-012 SHALL implement Status (addr 12: bit0 IE, bit1 EXL, others read 0), Cause (13), EPC (14), Count (9); other addresses read 32'h0.
REQ-013 SHALL implement FSM states IDLE, FLUSH, HANDLER, RETURN.
REQ-014 IDLE with exception=1 SHALL next cycle: Cause[2:0]<=cause_in[2:0], EPC<=epc_in, EXL<=1, state<=FLUSH.
REQ-015 FLUSH SHALL last exactly one cycle with flush=1, pc_redirect=1, redirect_pc=HANDLER_VECTOR, then go to HANDLER.
REQ-016 HANDLER SHALL hold EXL=1; exception=1 here SHALL NOT change EPC or Cause[2:0] but SHALL set sticky Cause[3] (nested fault).
REQ-017 HANDLER with eret=1 SHALL go to RETURN; eret in any other state SHALL be ignored.
REQ-018 RETURN SHALL last one cycle with flush=1, pc_redirect=1, redirect_pc=EPC, clear EXL at its end, then go to IDLE.
REQ-019 Outside FLUSH/RETURN, flush, pc_redirect SHALL be 0 and redirect_pc SHALL be 32'h0.
REQ-020 mtc0 writes SHALL be accepted only in IDLE and HANDLER; ignored in FLUSH/RETURN.
REQ-021 Simultaneous exception and mtc0 to Status/Cause/EPC in IDLE: exception update SHALL win; mtc0 to Count still applies.
REQ-022 Simultaneous eret and exception in HANDLER: eret SHALL win and Cause[3] SHALL still be set.
REQ-023 Cause[3] SHALL clear only via mtc0 to Cause or reset; mtc0 to Cause writes bits[3:0] only.
REQ-024 Count SHALL increment every cycle, wrap 32'hFFFF_FFFF->0; mtc0 to Count loads wr_data with no increment that cycle.
REQ-025 rd_data SHALL reflect register values before the current edge (no write bypass).

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, Status=0, Cause=0, EPC=0, Count=0, regardless of state, including mid FLUSH/RETURN.
REQ-027 During and one cycle after reset, flush=0, pc_redirect=0, redirect_pc=0, exl=0.

Configuration
REQ-028 Macro CP0_EXT_INT_EN SHALL, when defined, add port ext_int  input  1 and Cause[10] (IP2, level, reflects ext_int each cycle).
REQ-029 With CP0_EXT_INT_EN, IDLE with ext_int=1, IE=1, EXL=0, exception=0 SHALL take the REQ-014 path with Cause[2:0]<=0, EPC<=epc_in.
REQ-030 With CP0_EXT_INT_EN, exception=1 SHALL take priority over ext_int in the same cycle.
REQ-031 Without CP0_EXT_INT_EN, ext_int SHALL not exist and Cause[10] SHALL read 0.

Verification
REQ-032 Overflow trap: IDLE, exception=1, cause_in=4, epc_in=32'h0000_0040 -> next cycle flush=1, redirect_pc=32'h180; EPC=32'h40, Cause=4, exl=1.
REQ-033 Return: in HANDLER assert eret -> one cycle flush=1, redirect_pc=32'h40, then exl=0, state IDLE.
REQ-034 Nested: in HANDLER, exception=1, cause_in=1, epc_in=32'h80 -> EPC stays 32'h40, Cause reads 32'hC.
REQ-035 Count: mtc0 addr 9 data 32'hFFFF_FFFE -> reads FFFF_FFFE, FFFF_FFFF, 0000_0000 on following cycles.
REQ-036 Reset mid FLUSH: rst=1 during FLUSH -> next cycle all outputs 0, Cause/EPC read 0.
REQ-037 With CP0_EXT_INT_EN: Status=1, ext_int=1, epc_in=32'h20 -> redirect to 32'h180, EPC=32'h20, Cause[10]=1.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit: minimal MIPS-style coprocessor 0 for a 5-stage pipeline.
// Holds Status/Cause/EPC/Count, sequences exception entry and eret through a
// small FSM and drives the pipeline flush/redirect controls.
// Optional feature: define CP0_EXT_INT_EN to add the ext_int port, the level
// sensitive Cause[10] (IP2) bit and external interrupt entry.
module cp0_exception_unit #(
    parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception,
    input  logic [31:0] cause_in,
    input  logic [31:0] epc_in,
    input  logic        eret,
    input  logic        mtc0_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr,
`ifdef CP0_EXT_INT_EN
    input  logic        ext_int,
`endif
    output logic [31:0] rd_data,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        exl
);

    localparam logic [4:0] ADDR_COUNT  = 5'd9;
    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_t;

    state_t      state_q;
    logic        ie_q;
    logic        exl_q;
    logic [3:0]  cause_q;
    logic        ip2_q;
    logic [31:0] epc_q;
    logic [31:0] count_q;
    logic        flush_q;
    logic [31:0] redirect_pc_q;

    logic        ext_level;
    logic        accept_wr;
    logic        wr_count;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        take_irq;
    logic        take_trap;
    logic        unused_cause;

    // Only the low three cause bits carry meaning; the rest are deliberately dropped.
    assign unused_cause = ^cause_in[31:3];

`ifdef CP0_EXT_INT_EN
    assign ext_level = ext_int;
`else
    assign ext_level = 1'b0;
`endif

    // Decode CP0 write enables (writes are dropped while a redirect is in flight) and trap entry conditions.
    always_comb begin
        accept_wr = (state_q == IDLE) || (state_q == HANDLER);
        wr_count  = accept_wr && mtc0_en && (wr_addr == ADDR_COUNT);
        wr_status = accept_wr && mtc0_en && (wr_addr == ADDR_STATUS);
        wr_cause  = accept_wr && mtc0_en && (wr_addr == ADDR_CAUSE);
        wr_epc    = accept_wr && mtc0_en && (wr_addr == ADDR_EPC);
        take_irq  = ext_level && ie_q && !exl_q && !exception;
        take_trap = (state_q == IDLE) && (exception || take_irq);
    end

    // Exception FSM together with the CP0 register file and the registered pipeline controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ie_q          <= 1'b0;
            exl_q         <= 1'b0;
            cause_q       <= 4'b0;
            ip2_q         <= 1'b0;
            epc_q         <= 32'h0;
            count_q       <= 32'h0;
            flush_q       <= 1'b0;
            redirect_pc_q <= 32'h0;
        end else begin
            flush_q       <= 1'b0;
            redirect_pc_q <= 32'h0;
            ip2_q         <= ext_level;
            count_q       <= wr_count ? wr_data : count_q + 32'd1;

            unique case (state_q)
                IDLE: begin
                    if (take_trap) begin
                        cause_q[2:0]  <= exception ? cause_in[2:0] : 3'b000;
                        epc_q         <= epc_in;
                        exl_q         <= 1'b1;
                        state_q       <= FLUSH;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= HANDLER_VECTOR;
                    end else begin
                        if (wr_status) begin
                            ie_q  <= wr_data[0];
                            exl_q <= wr_data[1];
                        end
                        if (wr_cause) begin
                            cause_q <= wr_data[3:0];
                        end
                        if (wr_epc) begin
                            epc_q <= wr_data;
                        end
                    end
                end

                FLUSH: begin
                    state_q <= HANDLER;
                end

                HANDLER: begin
                    if (wr_status) begin
                        ie_q <= wr_data[0];
                    end
                    if (wr_cause) begin
                        cause_q <= wr_data[3:0];
                    end
                    if (wr_epc) begin
                        epc_q <= wr_data;
                    end
                    if (exception) begin
                        cause_q[3] <= 1'b1;
                    end
                    if (eret) begin
                        state_q       <= RETURN;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= wr_epc ? wr_data : epc_q;
                    end
                end

                RETURN: begin
                    exl_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Combinational mfc0 read of the pre-edge register values.
    always_comb begin
        rd_data = 32'h0;
        case (rd_addr)
            ADDR_STATUS: rd_data = {30'b0, exl_q, ie_q};
            ADDR_CAUSE:  rd_data = {21'b0, ip2_q, 6'b0, cause_q};
            ADDR_EPC:    rd_data = epc_q;
            ADDR_COUNT:  rd_data = count_q;
            default:     rd_data = 32'h0;
        endcase
    end

    assign flush       = flush_q;
    assign pc_redirect = flush_q;
    assign redirect_pc = redirect_pc_q;
    assign exl         = exl_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Testbench for cp0_exception_unit: directed scenarios plus a randomized run
// compared against a behavioural CP0 model.
module tb_cp0_exception_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exception = 1'b0;
    logic [31:0] cause_in = 32'h0;
    logic [31:0] epc_in = 32'h0;
    logic        eret = 1'b0;
    logic        mtc0_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'h0;
    logic [4:0]  rd_addr = 5'd0;
    logic [31:0] rd_data;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        exl;
`ifdef CP0_EXT_INT_EN
    logic        extInt = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model: architectural registers plus the pending redirect kind
    // (0 none, 1 to handler vector, 2 back to EPC) and whether a handler runs.
    logic        mIe;
    logic        mExl;
    logic [3:0]  mCause;
    logic        mIp2;
    logic [31:0] mEpc;
    logic [31:0] mCount;
    logic [31:0] mRetPc;
    int          mPulse;
    bit          mInHandler;

    cp0_exception_unit #(.HANDLER_VECTOR(32'h0000_0180)) dut (
        .clk(clk),
        .rst(rst),
        .exception(exception),
        .cause_in(cause_in),
        .epc_in(epc_in),
        .eret(eret),
        .mtc0_en(mtc0_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
`ifdef CP0_EXT_INT_EN
        .ext_int(extInt),
`endif
        .rd_data(rd_data),
        .flush(flush),
        .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc),
        .exl(exl)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        case (a)
            5'd9:    return mCount;
            5'd12:   return {30'b0, mExl, mIe};
            5'd13:   return {21'b0, mIp2, 6'b0, mCause};
            5'd14:   return mEpc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] modelRedirect();
        if (mPulse == 1) return 32'h0000_0180;
        if (mPulse == 2) return mRetPc;
        return 32'h0;
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic modelStep();
        logic [31:0] nextCount;
        logic        trap;
        if (rst) begin
            mIe = 0; mExl = 0; mCause = 0; mIp2 = 0; mEpc = 0; mCount = 0;
            mRetPc = 0; mPulse = 0; mInHandler = 0;
            return;
        end
        nextCount = mCount + 32'd1;
        if (mPulse == 1) begin
            mPulse = 0;
            mInHandler = 1;
        end else if (mPulse == 2) begin
            mPulse = 0;
            mInHandler = 0;
            mExl = 0;
        end else begin
            if (mtc0_en && wr_addr == 5'd9) nextCount = wr_data;
            if (mInHandler) begin
                if (mtc0_en && wr_addr == 5'd12) mIe = wr_data[0];
                if (mtc0_en && wr_addr == 5'd13) mCause = wr_data[3:0];
                if (mtc0_en && wr_addr == 5'd14) mEpc = wr_data;
                if (exception) mCause[3] = 1'b1;
                if (eret) begin
                    mPulse = 2;
                    mRetPc = mEpc;
                end
            end else begin
                trap = exception;
`ifdef CP0_EXT_INT_EN
                if (extInt && mIe && !mExl) trap = 1'b1;
`endif
                if (trap) begin
                    mCause[2:0] = exception ? cause_in[2:0] : 3'b000;
                    mEpc = epc_in;
                    mExl = 1'b1;
                    mPulse = 1;
                end else if (mtc0_en) begin
                    if (wr_addr == 5'd12) begin
                        mIe = wr_data[0];
                        mExl = wr_data[1];
                    end
                    if (wr_addr == 5'd13) mCause = wr_data[3:0];
                    if (wr_addr == 5'd14) mEpc = wr_data;
                end
            end
        end
        mCount = nextCount;
`ifdef CP0_EXT_INT_EN
        mIp2 = extInt;
`endif
    endtask

    task automatic stepClock();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic peek(input logic [4:0] a);
        rd_addr = a;
        #1;
    endtask

    task automatic applyStimulus();
        int pick;
        rst       = ($urandom_range(0, 99) < 2);
        exception = ($urandom_range(0, 99) < 15);
        cause_in  = $urandom;
        epc_in    = $urandom;
        eret      = ($urandom_range(0, 99) < 25);
        mtc0_en   = ($urandom_range(0, 99) < 20);
        pick      = $urandom_range(0, 4);
        case (pick)
            0: wr_addr = 5'd9;
            1: wr_addr = 5'd12;
            2: wr_addr = 5'd13;
            3: wr_addr = 5'd14;
            default: wr_addr = 5'($urandom_range(0, 31));
        endcase
        wr_data = $urandom;
        pick = $urandom_range(0, 4);
        case (pick)
            0: rd_addr = 5'd9;
            1: rd_addr = 5'd12;
            2: rd_addr = 5'd13;
            3: rd_addr = 5'd14;
            default: rd_addr = 5'($urandom_range(0, 31));
        endcase
`ifdef CP0_EXT_INT_EN
        extInt = ($urandom_range(0, 99) < 20);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stepClock();
        stepClock();
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL rst_flush got %h expected 0", flush); end
        checks++; if (pc_redirect !== 1'b0) begin errors++; $display("[TB] FAIL rst_redirect got %h expected 0", pc_redirect); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_redirect_pc got %h expected 0", redirect_pc); end
        checks++; if (exl !== 1'b0) begin errors++; $display("[TB] FAIL rst_exl got %h expected 0", exl); end
        rst = 1'b0;
        stepClock();
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_flush got %h expected 0", flush); end
        checks++; if (exl !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_exl got %h expected 0", exl); end
        peek(5'd12);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_status got %h expected 0", rd_data); end
        peek(5'd13);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_cause got %h expected 0", rd_data); end
        peek(5'd14);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_epc got %h expected 0", rd_data); end
        peek(5'd9);
        checks++; if (rd_data !== 32'h1) begin errors++; $display("[TB] FAIL rst_count got %h expected 1", rd_data); end
    endtask

    task automatic test_overflow_trap();
        exception = 1'b1; cause_in = 32'd4; epc_in = 32'h0000_0040;
        stepClock();
        exception = 1'b0; cause_in = 32'h0; epc_in = 32'h0;
        checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL trap_flush got %h expected 1", flush); end
        checks++; if (pc_redirect !== 1'b1) begin errors++; $display("[TB] FAIL trap_redirect got %h expected 1", pc_redirect); end
        checks++; if (redirect_pc !== 32'h180) begin errors++; $display("[TB] FAIL trap_vector got %h expected 180", redirect_pc); end
        checks++; if (exl !== 1'b1) begin errors++; $display("[TB] FAIL trap_exl got %h expected 1", exl); end
        peek(5'd14);
        checks++; if (rd_data !== 32'h40) begin errors++; $display("[TB] FAIL trap_epc got %h expected 40", rd_data); end
        peek(5'd13);
        checks++; if (rd_data !== 32'h4) begin errors++; $display("[TB] FAIL trap_cause got %h expected 4", rd_data); end
        stepClock();
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL handler_flush got %h expected 0", flush); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL handler_redirect_pc got %h expected 0", redirect_pc); end
        checks++; if (exl !== 1'b1) begin errors++; $display("[TB] FAIL handler_exl got %h expected 1", exl); end
    endtask

    task automatic test_nested();
        exception = 1'b1; cause_in = 32'd1; epc_in = 32'h0000_0080;
        stepClock();
        exception = 1'b0; cause_in = 32'h0; epc_in = 32'h0;
        peek(5'd14);
        checks++; if (rd_data !== 32'h40) begin errors++; $display("[TB] FAIL nested_epc got %h expected 40", rd_data); end
        peek(5'd13);
        checks++; if (rd_data !== 32'hC) begin errors++; $display("[TB] FAIL nested_cause got %h expected c", rd_data); end
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL nested_flush got %h expected 0", flush); end
    endtask

    task automatic test_return();
        eret = 1'b1;
        stepClock();
        eret = 1'b0;
        checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL ret_flush got %h expected 1", flush); end
        checks++; if (redirect_pc !== 32'h40) begin errors++; $display("[TB] FAIL ret_pc got %h expected 40", redirect_pc); end
        checks++; if (exl !== 1'b1) begin errors++; $display("[TB] FAIL ret_exl_during got %h expected 1", exl); end
        stepClock();
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL ret_done_flush got %h expected 0", flush); end
        checks++; if (exl !== 1'b0) begin errors++; $display("[TB] FAIL ret_done_exl got %h expected 0", exl); end
        eret = 1'b1;
        stepClock();
        eret = 1'b0;
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL idle_eret_flush got %h expected 0", flush); end
        mtc0_en = 1'b1; wr_addr = 5'd13; wr_data = 32'hFFFF_FFF0;
        stepClock();
        mtc0_en = 1'b0;
        peek(5'd13);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL cause_clear got %h expected 0", rd_data); end
    endtask

    task automatic test_count_wrap();
        mtc0_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFF_FFFE;
        stepClock();
        mtc0_en = 1'b0;
        peek(5'd9);
        checks++; if (rd_data !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL count_load got %h expected fffffffe", rd_data); end
        stepClock();
        checks++; if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL count_inc got %h expected ffffffff", rd_data); end
        stepClock();
        checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL count_wrap got %h expected 0", rd_data); end
    endtask

    task automatic test_back_to_back();
        exception = 1'b1; cause_in = 32'd2; epc_in = 32'h0000_0100;
        mtc0_en = 1'b1; wr_addr = 5'd14; wr_data = 32'h0000_0555;
        stepClock();
        exception = 1'b0;
        peek(5'd14);
        checks++; if (rd_data !== 32'h100) begin errors++; $display("[TB] FAIL race_epc got %h expected 100", rd_data); end
        peek(5'd13);
        checks++; if (rd_data !== 32'h2) begin errors++; $display("[TB] FAIL race_cause got %h expected 2", rd_data); end
        wr_addr = 5'd14; wr_data = 32'h0000_0999;
        stepClock();
        mtc0_en = 1'b0;
        peek(5'd14);
        checks++; if (rd_data !== 32'h100) begin errors++; $display("[TB] FAIL flush_write_ignored got %h expected 100", rd_data); end
        eret = 1'b1; exception = 1'b1; cause_in = 32'd4;
        stepClock();
        eret = 1'b0; exception = 1'b0;
        checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL eret_wins_flush got %h expected 1", flush); end
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("[TB] FAIL eret_wins_pc got %h expected 100", redirect_pc); end
        peek(5'd13);
        checks++; if (rd_data !== 32'hA) begin errors++; $display("[TB] FAIL eret_nested_cause got %h expected a", rd_data); end
        stepClock();
    endtask

    task automatic test_reset_mid_flush();
        exception = 1'b1; cause_in = 32'd4; epc_in = 32'h0000_0044;
        stepClock();
        exception = 1'b0;
        checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_flush got %h expected 1", flush); end
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        checks++; if ({flush, pc_redirect, exl} !== 3'b000) begin errors++; $display("[TB] FAIL midflush_ctrl got %b expected 000", {flush, pc_redirect, exl}); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL midflush_pc got %h expected 0", redirect_pc); end
        peek(5'd13);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL midflush_cause got %h expected 0", rd_data); end
        peek(5'd14);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL midflush_epc got %h expected 0", rd_data); end
        stepClock();
        checks++; if ({flush, pc_redirect, exl} !== 3'b000) begin errors++; $display("[TB] FAIL after_rst_ctrl got %b expected 000", {flush, pc_redirect, exl}); end
    endtask

`ifdef CP0_EXT_INT_EN
    task automatic test_ext_int();
        mtc0_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h1;
        stepClock();
        mtc0_en = 1'b0;
        extInt = 1'b1; epc_in = 32'h0000_0020;
        stepClock();
        extInt = 1'b0;
        checks++; if (redirect_pc !== 32'h180) begin errors++; $display("[TB] FAIL irq_vector got %h expected 180", redirect_pc); end
        peek(5'd14);
        checks++; if (rd_data !== 32'h20) begin errors++; $display("[TB] FAIL irq_epc got %h expected 20", rd_data); end
        peek(5'd13);
        checks++; if ((rd_data & 32'h407) !== 32'h400) begin errors++; $display("[TB] FAIL irq_cause got %h expected ip2 set code 0", rd_data); end
        stepClock();
        eret = 1'b1;
        stepClock();
        eret = 1'b0;
        stepClock();
        mtc0_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0;
        stepClock();
        mtc0_en = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            applyStimulus();
            stepClock();
            checks++; if (flush !== (mPulse != 0)) begin errors++; $display("[TB] FAIL rand_flush cycle %0d got %h expected %h", i, flush, (mPulse != 0)); end
            checks++; if (pc_redirect !== (mPulse != 0)) begin errors++; $display("[TB] FAIL rand_redirect cycle %0d got %h expected %h", i, pc_redirect, (mPulse != 0)); end
            checks++; if (redirect_pc !== modelRedirect()) begin errors++; $display("[TB] FAIL rand_redirect_pc cycle %0d got %h expected %h", i, redirect_pc, modelRedirect()); end
            checks++; if (exl !== mExl) begin errors++; $display("[TB] FAIL rand_exl cycle %0d got %h expected %h", i, exl, mExl); end
            checks++; if (rd_data !== modelRead(rd_addr)) begin errors++; $display("[TB] FAIL rand_rd addr %0d cycle %0d got %h expected %h", rd_addr, i, rd_data, modelRead(rd_addr)); end
        end
    endtask

    initial begin
        test_reset();
        test_overflow_trap();
        test_nested();
        test_return();
        test_count_wrap();
        test_back_to_back();
        test_reset_mid_flush();
`ifdef CP0_EXT_INT_EN
        test_ext_int();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
